// File: rtl/prefix_adder_pipe.sv
// Segmented, pipelined add/subtract unit. Each stage adds one SEG-bit slice
// and hands its carry to the next stage. Unconsumed operand slices ride along
// with the partial sum. The pipeline has one global stall and a valid/ready
// handshake on both sides.
module prefix_adder_pipe #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SEG   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned N     = WIDTH / SEG;
   localparam int unsigned SEG_W = SEG + 1;

   // Reject geometries that cannot be split into whole segments.
   if ((SEG == 0) || (WIDTH < SEG) || ((WIDTH % SEG) != 0)) begin : g_param_check
      $error("prefix_adder_pipe: WIDTH must be a non-zero multiple of SEG");
   end

   // Per-stage registered state.
   logic [WIDTH-1:0] a_q [N];
   logic [WIDTH-1:0] b_q [N];
   logic [WIDTH-1:0] s_q [N];
   logic             c_q [N];
   logic             v_q [N];
   logic             ovf_q;

   // Inputs seen by each stage: the ports for stage 0, the previous stage otherwise.
   logic [WIDTH-1:0] a_src [N];
   logic [WIDTH-1:0] b_src [N];
   logic [WIDTH-1:0] s_src [N];
   logic             c_src [N];
   logic             v_src [N];

   // Next-state values produced by each stage's segment add.
   logic [WIDTH-1:0] s_d [N];
   logic             c_d [N];
   logic             ovf_d;

   // The pipeline advances whenever the output is not held by back-pressure.
   assign in_ready = ~(v_q[N-1] & ~out_ready);

   assign out_valid = v_q[N-1];
   assign sum       = s_q[N-1];
   assign cout      = c_q[N-1];
   assign ovf       = ovf_q;

   // Route each stage's operands, partial sum, carry and valid bit.
   // Subtract is folded in at entry: B = ~b and the carry-in is inverted.
   always_comb begin
      for (int unsigned j = 0; j < N; j++) begin
         a_src[j] = '0;
         b_src[j] = '0;
         s_src[j] = '0;
         c_src[j] = 1'b0;
         v_src[j] = 1'b0;
      end
      a_src[0] = a;
      b_src[0] = sub ? ~b : b;
      s_src[0] = '0;
      c_src[0] = cin ^ sub;
      v_src[0] = in_valid;
      for (int unsigned j = 1; j < N; j++) begin
         a_src[j] = a_q[j-1];
         b_src[j] = b_q[j-1];
         s_src[j] = s_q[j-1];
         c_src[j] = c_q[j-1];
         v_src[j] = v_q[j-1];
      end
   end

   // One SEG-bit add per stage. The last stage also derives signed overflow
   // from the carry into the MSB, which is recovered as a ^ B ^ sum at that bit.
   always_comb begin : seg_add
      logic [SEG:0] seg_sum;
      seg_sum = '0;
      for (int unsigned j = 0; j < N; j++) begin
         s_d[j]  = s_src[j];
         seg_sum = {1'b0, a_src[j][j*SEG +: SEG]}
                 + {1'b0, b_src[j][j*SEG +: SEG]}
                 + SEG_W'(c_src[j]);
         s_d[j][j*SEG +: SEG] = seg_sum[SEG-1:0];
         c_d[j]  = seg_sum[SEG];
      end
      ovf_d = a_src[N-1][WIDTH-1] ^ b_src[N-1][WIDTH-1]
            ^ s_d[N-1][WIDTH-1] ^ c_d[N-1];
   end

   // Stage registers. All stages shift together unless stalled. Payloads load
   // only with a valid token, so bubbles leave the last result untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned j = 0; j < N; j++) begin
            a_q[j] <= '0;
            b_q[j] <= '0;
            s_q[j] <= '0;
            c_q[j] <= 1'b0;
            v_q[j] <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else if (in_ready) begin
         for (int unsigned j = 0; j < N; j++) begin
            v_q[j] <= v_src[j];
            if (v_src[j]) begin
               a_q[j] <= a_src[j];
               b_q[j] <= b_src[j];
               s_q[j] <= s_d[j];
               c_q[j] <= c_d[j];
            end
         end
         if (v_src[N-1]) begin
            ovf_q <= ovf_d;
         end
      end
   end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Directed and random checks of prefix_adder_pipe (WIDTH=16, SEG=4), with a
// scoreboard queue of expected {sum, cout, ovf} values.
module tb_prefix_adder_pipe;

   localparam int unsigned W = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          cin = 1'b0;
   logic          sub = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  sum;
   logic          cout;
   logic          ovf;

   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   logic [17:0]   exp_q [$];
   logic          dir_en = 1'b0;
   logic [17:0]   dir_exp = '0;
   bit            pop_mark = 1'b0;
   int            first_pop = 0;
   int            last_pop = 0;
   int            npops = 0;
   logic [17:0]   snap;

   prefix_adder_pipe #(.WIDTH(16), .SEG(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   // Reference: full-width add plus a 15-bit add to get the carry into the MSB.
   function automatic logic [17:0] model(input logic [15:0] aa, input logic [15:0] bb,
                                         input logic ci, input logic sb);
      logic [15:0] bo;
      logic [16:0] full;
      logic [15:0] low;
      logic        c0;
      bo   = sb ? ~bb : bb;
      c0   = ci ^ sb;
      full = {1'b0, aa} + {1'b0, bo} + 17'(c0);
      low  = {1'b0, aa[14:0]} + {1'b0, bo[14:0]} + 16'(c0);
      return {full[15:0], full[16], low[15] ^ full[16]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Called at a negedge with inputs already driven: score the transfers that
   // the next rising edge will perform, then advance to the following negedge.
   task automatic step();
      logic        in_fire;
      logic        out_fire;
      logic [17:0] e;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
         if (exp_q.size() == 0) begin
            check("spurious_result", 32'(out_valid), 32'(0));
         end else begin
            e = exp_q.pop_front();
            check("result", 32'({sum, cout, ovf}), 32'(e));
         end
         if (pop_mark) begin
            first_pop = cyc;
            pop_mark  = 1'b0;
         end
         last_pop = cyc;
         npops++;
      end
      if (in_fire) begin
         exp_q.push_back(dir_en ? dir_exp : model(a, b, cin, sub));
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic put(input logic [15:0] aa, input logic [15:0] bb, input logic ci,
                      input logic sb, input logic [17:0] ex, input logic use_ex);
      a = aa; b = bb; cin = ci; sub = sb; in_valid = 1'b1;
      dir_en = use_ex; dir_exp = ex;
      step();
      in_valid = 1'b0;
      dir_en = 1'b0;
   endtask

   task automatic put_rand();
      put(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), '0, 1'b0);
   endtask

   // Single transfer on an idle pipe; measure edges until out_valid, then pop.
   task automatic send_lat(input string tag, input logic [15:0] aa, input logic [15:0] bb,
                           input logic ci, input logic sb, input logic [17:0] ex);
      int lat;
      check({tag, "_in_ready"}, 32'(in_ready), 32'(1));
      put(aa, bb, ci, sb, ex, 1'b1);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 12) begin
         step();
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(4));
      step();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (exp_q.size() > 0 && n < budget) begin
         step();
         n++;
      end
      check("drain_left", 32'(exp_q.size()), 32'(0));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      // Asynchronous reset before any clock edge.
      #1 rst_n = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_sum", 32'(sum), 32'(0));
      check("rst_cout", 32'(cout), 32'(0));
      check("rst_ovf", 32'(ovf), 32'(0));
      check("rst_in_ready", 32'(in_ready), 32'(1));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Add with wrap, including latency.
      send_lat("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0});

      // Subtract with borrow and signed-overflow cases, back to back.
      put(16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 1'b0, 1'b0}, 1'b1);
      put(16'h0005, 16'h0007, 1'b1, 1'b1, {16'hFFFD, 1'b0, 1'b0}, 1'b1);
      put(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1}, 1'b1);
      put(16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1}, 1'b1);
      drain(20);

      // Streaming: 8 random back-to-back transfers leave on consecutive cycles.
      pop_mark = 1'b1;
      npops    = 0;
      for (int i = 0; i < 8; i++) begin
         a = 16'($urandom); b = 16'($urandom);
         cin = 1'($urandom); sub = 1'($urandom);
         in_valid = 1'b1;
         step();
      end
      drain(20);
      check("stream_count", 32'(npops), 32'(8));
      check("stream_span", 32'(last_pop - first_pop), 32'(7));

      // Back-pressure: fill the pipe with out_ready low, then stall 3 cycles.
      out_ready = 1'b0;
      for (int i = 0; i < 10 && in_ready; i++) begin
         a = 16'($urandom); b = 16'($urandom);
         cin = 1'($urandom); sub = 1'($urandom);
         in_valid = 1'b1;
         step();
      end
      check("bp_filled", 32'(exp_q.size()), 32'(4));
      snap = {sum, cout, ovf};
      for (int i = 0; i < 3; i++) begin
         a = 16'($urandom); b = 16'($urandom);
         in_valid = 1'b1;
         check("bp_in_ready", 32'(in_ready), 32'(0));
         check("bp_out_valid", 32'(out_valid), 32'(1));
         check("bp_hold", 32'({sum, cout, ovf}), 32'(snap));
         step();
      end
      check("bp_hold_end", 32'({sum, cout, ovf}), 32'(snap));
      drain(20);
      for (int i = 0; i < 3; i++) begin
         check("bp_no_dup", 32'(out_valid), 32'(0));
         step();
      end

      // Reset with 3 transfers in flight.
      put_rand();
      put_rand();
      put_rand();
      check("rm_inflight", 32'(exp_q.size()), 32'(3));
      rst_n = 1'b0;
      #1;
      check("rm_out_valid", 32'(out_valid), 32'(0));
      check("rm_sum", 32'(sum), 32'(0));
      check("rm_in_ready", 32'(in_ready), 32'(1));
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      send_lat("after_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, {16'h5555, 1'b0, 1'b0});
      for (int i = 0; i < 4; i++) begin
         check("rm_no_stale", 32'(out_valid), 32'(0));
         step();
      end

      check("final_empty", 32'(exp_q.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prefix_adder_pipe.md
PREFIX_ADDER_PIPE -- requirements
Module: prefix_adder_pipe

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports and parameters as listed in REQ-002 to REQ-013.
REQ-002 Parameter WIDTH, default 16: operand and sum width; SHALL be a multiple of SEG and at least SEG.
REQ-003 Parameter SEG, default 4: segment width; the pipeline depth N SHALL equal WIDTH/SEG.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  the operand set on a, b, cin and sub is valid this cycle.
REQ-007 in_ready  output  1  the block accepts the operand set this cycle.
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 cin  input  1  carry-in for add, or borrow-in for subtract.
REQ-010 sub  input  1  0 = add, 1 = subtract (a - b).
REQ-011 out_valid  output  1  sum, cout and ovf hold a valid result.
REQ-012 out_ready  input  1  the consumer accepts the result this cycle.
REQ-013 sum  output  WIDTH; cout  output  1; ovf  output  1  result, carry-out and signed overflow.

Function
REQ-014 An input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; an output transfer SHALL occur where out_valid=1 and out_ready=1.
REQ-015 Arithmetic SHALL be performed as follows.
- Operand B is b when sub=0 and ~b when sub=1.
- Carry-in to segment 0 is cin XOR sub.
- sum = (a + B + carry-in) mod 2^WIDTH.
REQ-016 Carry and overflow outputs SHALL be defined as follows.
- cout is the carry out of bit WIDTH-1; for subtract, cout=1 means no borrow.
- ovf is the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-017 Pipeline operation SHALL be as follows.
- Stage j (0..N-1) computes segment j using the carry registered by stage j-1.
- Operand segments above j SHALL travel skewed alongside the partial result.
- No combinational path SHALL span more than one SEG-bit segment add.
REQ-018 Latency SHALL be N edges: a transfer accepted on edge k SHALL present out_valid=1 with its result after edge k+N-1, given no stall.
REQ-019 Throughput SHALL be one transfer per cycle when out_ready=1, and results SHALL leave in acceptance order.
REQ-020 The pipeline SHALL stall globally when out_valid=1 and out_ready=0.
- All stages, including valid bits, hold.
- in_ready = NOT(out_valid AND NOT out_ready), computed combinationally.
REQ-021 While out_valid=1 and out_ready=0, sum, cout and ovf SHALL remain stable.
REQ-022 Bubbles SHALL propagate as invalid stages.
- A stage whose valid bit is 0 SHALL NOT block the stages behind it while out_ready=1.
- Partial-stage bubble collapsing is not required.
REQ-023 When in_valid=1 and in_ready=0, the inputs SHALL be ignored, with no capture and no side effect.
REQ-024 Simultaneous input and output transfers in one cycle SHALL both complete with no loss or duplication.
REQ-025 With N=1 the block SHALL reduce to a single registered adder with latency 1 and the same handshake.

Reset
REQ-026 On rst_n=0, asynchronously and regardless of clk:
- all stage valid bits clear, so out_valid=0;
- sum=0, cout=0 and ovf=0;
- in_ready=1 once out_valid=0.
REQ-027 Transfers in flight at reset SHALL be discarded, and no result from them SHALL appear after reset release.
REQ-028 The first transfer after release SHALL be accepted on the first rising edge with rst_n=1 and in_valid=1.

Verification
All scenarios use WIDTH=16, SEG=4, N=4.
REQ-029 Add with wrap: a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0, out_valid after the 4th edge.
REQ-030 Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=0 -> sum=0xFFFE, cout=0, ovf=0.
- The same operands with cin=1 -> sum=0xFFFD.
REQ-031 Signed overflow: a=0x7FFF, b=0x0001, add -> sum=0x8000, cout=0, ovf=1.
- a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
REQ-032 Streaming: 8 back-to-back random transfers with out_ready=1 -> 8 results on consecutive cycles, in order, matching the reference model.
REQ-033 Backpressure: pipeline full, out_ready=0 for 3 cycles ->
- in_ready=0 and outputs stable during the stall;
- no loss or duplication after out_ready returns to 1.
REQ-034 Reset mid-flight: rst_n pulsed low with 3 transfers in flight ->
- out_valid=0 and sum=0 immediately;
- no stale result after release;
- the next transfer returns a correct result after 4 edges.
